weight_fetch_ctrl: RTL and testbench
====================================

# weight_fetch_ctrl

Initiator side of the kernel-serving handshake: requests convolution kernels one at a time from the weight server and latches each one. It presents each kernel to the convolution engine through a valid/ready handshake. It tracks the kernel index and detects end-of-set and protocol faults. It sits between the weight server and the conv/MAC engine, and its server-side ports wire one-to-one to the server's start/next_kernel/output_value/output_done/done.

## Interface
- DATA_WIDTH, 8, bits per weight
- K_H, 3, kernel height
- K_W, 3, kernel width
- NUM_KERNELS, 3, kernels per set (≥1)
- TIMEOUT, 255, max cycles waiting on the server before fault (≥4)
- KW (local) = DATA_WIDTH*K_H*K_W; IDX_W (local) = max(1, clog2(NUM_KERNELS))

Ports. Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin fetching a kernel set; ignored unless IDLE
- srv_start  out  1  1-cycle pulse to server start
- next_kernel  out  1  request level to server
- kernel_in  in  KW  server kernel data
- kernel_valid_in  in  1  server output_done pulse
- server_done  in  1  server done pulse
- kernel_out  out  KW  latched kernel
- kernel_idx  out  IDX_W  index of kernel_out
- out_valid  out  1  kernel_out valid to engine
- out_ready  in  1  engine accepts kernel_out
- busy  out  1  state != IDLE
- done  out  1  1-cycle end-of-set pulse
- error  out  1  sticky fault, cleared by accepted start or rst

## Operation
States are IDLE, REQ, HOLD, FINISH and DONE. All outputs are registered.
- IDLE: on start, go to REQ, set count=0, clear error and srv_done_seen, and pulse srv_start for 1 cycle.
- REQ: next_kernel=1.
  - On kernel_valid_in with server_done low: drop next_kernel, latch kernel_in into kernel_out, set kernel_idx=count and out_valid=1, go to HOLD.
  - On server_done: set error=1 and go to DONE (premature end).
- HOLD: next_kernel=0.
  - On out_valid&&out_ready: set out_valid=0.
    - If count==NUM_KERNELS-1, go to FINISH.
    - Otherwise count++ and go to REQ.
  - No timeout in HOLD, because the engine may stall indefinitely.
- FINISH: when srv_done_seen or server_done, go to DONE.
- DONE: done=1 for exactly 1 cycle, then go to IDLE. kernel_out and kernel_idx keep their last values.

srv_done_seen:
- Set by server_done in any non-IDLE state other than REQ.
- This covers the server raising done while the last kernel is still held.

kernel_valid_in:
- Ignored outside REQ. The server emits it alongside done with zero data.
- Never latched outside REQ.

Watchdog:
- The counter resets on every state entry.
- It increments in REQ and FINISH.
- When it reaches TIMEOUT: set error=1, drop next_kernel, go to DONE.

Simultaneous events:
- start in the DONE cycle is ignored.
- out_ready without out_valid has no effect.
- kernel_valid_in together with server_done in REQ counts as the error case.

Reset mid-operation: all registers return to reset values immediately and the state goes to IDLE. The server must be reset alongside.

## Timing
- Reset values: srv_start=0, next_kernel=0, kernel_out=0, kernel_idx=0, out_valid=0, busy=0, done=0, error=0, state=IDLE.
- Start handshake: start sampled at edge E means srv_start and next_kernel are high after E.
- next_kernel stays level-high until the edge that samples kernel_valid_in. It is low the following cycle, so a server that re-arms on output_done clearing is never double-requested.
- Latch latency: kernel_out and out_valid are valid 1 cycle after kernel_valid_in is sampled.
- Re-request: on accept (out_valid&&out_ready at edge A), next_kernel is high after A when more kernels remain.
- Back-to-back latency per kernel with out_ready tied high and a 1-cycle server response: 3 cycles (REQ, response, HOLD).
- End of set: done pulses the cycle after FINISH observes the server's done.

## Structure
- Shared package/header npu_weight_pkg holds:
  - state encodings (IDLE=0, REQ=1, HOLD=2, FINISH=3, DONE=4);
  - KW and IDX_W width functions;
  - the default TIMEOUT.
- Sub-module wf_watchdog: clear/enable inputs, TIMEOUT parameter, expired output. Counter width clog2(TIMEOUT+1).
- Everything else stays in one FSM plus a datapath register.

## Test plan
- Nominal: NUM_KERNELS=3, server model holds kernels 0x..11, 0x..22, 0x..33, out_ready=1 → kernel_out 0x11 (idx 0), 0x22 (idx 1), 0x33 (idx 2). Each out_valid lasts 1 cycle, one done pulse, error=0, exactly 3 next_kernel rising edges.
- Back-pressure: out_ready low for 20 cycles on kernel 1 → out_valid and kernel_out 0x22 held stable, next_kernel=0 throughout, no watchdog fault. The server's done arriving during the last HOLD is still honoured.
- Premature end: server asserts server_done after 1 kernel → error=1, done pulse, only 1 kernel delivered, busy=0 after.
- Timeout: server never answers, TIMEOUT=10 → next_kernel drops and error=1 exactly 10 cycles after REQ entry, then done pulse.
- Reset mid-set: rst asserted in HOLD of kernel 1 → all outputs 0 asynchronously. A following start fetches from idx 0 with error clear.
- Start ignored: start pulsed while busy and in the DONE cycle → no extra srv_start, sequence unchanged.

Source files
------------

// File: rtl/npu_weight_pkg.sv
// Shared definitions for the weight-fetch path: FSM state encoding,
// derived width helpers and the default server watchdog limit.
package npu_weight_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_HOLD   = 3'd2,
      ST_FINISH = 3'd3,
      ST_DONE   = 3'd4
   } wf_state_t;

   localparam int unsigned DEFAULT_TIMEOUT = 255;

   function automatic int unsigned kernel_width(input int unsigned dw,
                                                input int unsigned kh,
                                                input int unsigned kw);
      return dw * kh * kw;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wf_watchdog.sv
// Cycle watchdog for server waits: counts while enabled, flags expiry on the
// TIMEOUT-th enabled cycle since the last clear.
module wf_watchdog
   import npu_weight_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   // count holds elapsed enabled cycles minus one, so expiry lines up with the
   // edge that ends the TIMEOUT-th cycle
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

   always_comb begin
      expired = enable && (count == LIMIT);
   end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Kernel fetch initiator: requests kernels from the weight server one at a
// time, latches each and presents it to the conv engine via valid/ready.
module weight_fetch_ctrl
   import npu_weight_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned K_H         = 3,
   parameter int unsigned K_W         = 3,
   parameter int unsigned NUM_KERNELS = 3,
   parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
   localparam int unsigned KW    = kernel_width(DATA_WIDTH, K_H, K_W),
   localparam int unsigned IDX_W = idx_width(NUM_KERNELS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             srv_start,
   output logic             next_kernel,
   input  logic [KW-1:0]    kernel_in,
   input  logic             kernel_valid_in,
   input  logic             server_done,
   output logic [KW-1:0]    kernel_out,
   output logic [IDX_W-1:0] kernel_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KERNELS - 1);

   wf_state_t        state;
   logic [IDX_W-1:0] count;
   logic             srv_done_seen;
   logic             wd_enable;
   logic             wd_clear;
   logic             wd_expired;

   // Watched states are only ever entered from unwatched ones, so holding the
   // counter clear outside them restarts it on every state entry.
   always_comb begin
      wd_enable = (state == ST_REQ) || (state == ST_FINISH);
      wd_clear  = !wd_enable;
   end

   wf_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         count         <= '0;
         srv_done_seen <= 1'b0;
         srv_start     <= 1'b0;
         next_kernel   <= 1'b0;
         kernel_out    <= '0;
         kernel_idx    <= '0;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         srv_start <= 1'b0;
         done      <= 1'b0;

         // Server may finish while the last kernel is still held by the engine
         if (server_done && (state != ST_IDLE) && (state != ST_REQ))
            srv_done_seen <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state         <= ST_REQ;
                  count         <= '0;
                  error         <= 1'b0;
                  srv_done_seen <= 1'b0;
                  srv_start     <= 1'b1;
                  next_kernel   <= 1'b1;
                  busy          <= 1'b1;
               end
            end

            ST_REQ: begin
               if (server_done) begin
                  error       <= 1'b1;
                  next_kernel <= 1'b0;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end else if (kernel_valid_in) begin
                  next_kernel <= 1'b0;
                  kernel_out  <= kernel_in;
                  kernel_idx  <= count;
                  out_valid   <= 1'b1;
                  state       <= ST_HOLD;
               end else if (wd_expired) begin
                  error       <= 1'b1;
                  next_kernel <= 1'b0;
                  done        <= 1'b1;
                  state       <= ST_DONE;
               end
            end

            ST_HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (count == LAST_IDX) begin
                     state <= ST_FINISH;
                  end else begin
                     count       <= count + 1'b1;
                     next_kernel <= 1'b1;
                     state       <= ST_REQ;
                  end
               end
            end

            ST_FINISH: begin
               if (srv_done_seen || server_done) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (wd_expired) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               next_kernel <= 1'b0;
               out_valid   <= 1'b0;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: behavioural weight server and
// engine, expected deliveries derived from the server's kernel table.
module tb_weight_fetch_ctrl;

   localparam int NK = 3;
   localparam int KW = 72;
   localparam int TO = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          srv_start;
   logic          next_kernel;
   logic [KW-1:0] kernel_in = '0;
   logic          kernel_valid_in = 1'b0;
   logic          server_done = 1'b0;
   logic [KW-1:0] kernel_out;
   logic [1:0]    kernel_idx;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          done;
   logic          error;

   weight_fetch_ctrl #(
      .DATA_WIDTH  (8),
      .K_H         (3),
      .K_W         (3),
      .NUM_KERNELS (NK),
      .TIMEOUT     (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .srv_start       (srv_start),
      .next_kernel     (next_kernel),
      .kernel_in       (kernel_in),
      .kernel_valid_in (kernel_valid_in),
      .server_done     (server_done),
      .kernel_out      (kernel_out),
      .kernel_idx      (kernel_idx),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // server model configuration / state
   logic [KW-1:0] srv_mem [NK];
   int srv_limit = NK;
   int srv_delay = 0;
   int srv_done_delay = 0;
   bit srv_silent = 0;
   int srv_wait = -1;
   int srv_served = 0;
   int srv_done_cnt = -1;

   // engine model configuration
   int ready_mode = 0;
   int stall_left [NK];
   bit poke_busy = 0;
   bit poke_done = 0;

   // monitor
   int cyc = 0;
   int n_srv_start, nk_rises, n_done, n_valid_cyc, nk_in_hold, unstable;
   bit nk_prev = 0, ov_prev = 0, or_prev = 0;
   logic [KW-1:0] ko_prev;
   logic [1:0]    ki_prev;
   logic [KW-1:0] got_data [$];
   int got_idx [$];
   int acc_cyc [$];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (srv_start) begin
         n_srv_start++;
         srv_served = 0; srv_wait = -1; srv_done_cnt = -1;
      end
      if (next_kernel && !nk_prev) nk_rises++;
      nk_prev = next_kernel;
      if (done) n_done++;
      if (out_valid) n_valid_cyc++;
      if (out_valid && next_kernel) nk_in_hold++;
      if (out_valid && ov_prev && !or_prev &&
          (kernel_out !== ko_prev || kernel_idx !== ki_prev)) unstable++;

      start = 1'b0; kernel_valid_in = 1'b0; server_done = 1'b0; kernel_in = '0;
      if (poke_busy && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      if (poke_done && done) start = 1'b1;

      // server: done pulse comes with a zero-data output_done
      if (srv_done_cnt == 0) begin
         server_done = 1'b1; kernel_valid_in = 1'b1; srv_done_cnt = -1;
      end else if (srv_done_cnt > 0) srv_done_cnt--;
      if (srv_wait > 0) srv_wait--;
      else if (srv_wait == 0) begin
         srv_wait = -1;
         if (srv_served >= srv_limit) begin
            server_done = 1'b1; kernel_valid_in = 1'b1;
         end else begin
            kernel_in = srv_mem[srv_served];
            kernel_valid_in = 1'b1;
            srv_served++;
            if (srv_served == NK) srv_done_cnt = srv_done_delay;
         end
      end else if (next_kernel && !srv_silent) srv_wait = srv_delay;

      // engine
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            if (out_valid && stall_left[kernel_idx] > 0) begin
               out_ready = 1'b0; stall_left[kernel_idx]--;
            end else out_ready = 1'b1;
         end
      endcase
      if (out_valid && out_ready) begin
         got_data.push_back(kernel_out);
         got_idx.push_back(int'(kernel_idx));
         acc_cyc.push_back(cyc);
      end
      ov_prev = out_valid; or_prev = out_ready; ko_prev = kernel_out; ki_prev = kernel_idx;
   endtask

   task automatic run_set(input int budget);
      n_srv_start = 0; nk_rises = 0; n_done = 0; n_valid_cyc = 0;
      nk_in_hold = 0; unstable = 0;
      got_data.delete(); got_idx.delete(); acc_cyc.delete();
      start = 1'b1;
      for (int i = 0; i < budget && n_done == 0; i++) step();
      step();
   endtask

   task automatic fill_random();
      for (int i = 0; i < NK; i++) srv_mem[i] = KW'({$urandom, $urandom, $urandom});
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({srv_start, next_kernel, kernel_out, kernel_idx, out_valid, busy, done, error} !== '0)
         $display("FAIL reset_outputs got %h exp 0",
                  {srv_start, next_kernel, kernel_out, kernel_idx, out_valid, busy, done, error});
      else n_pass++;
      @(negedge clk) rst = 1'b0;
      step(); step();
      n_checks++;
      if ({busy, next_kernel, out_valid} !== 3'b000)
         $display("FAIL reset_idle got %b exp 000", {busy, next_kernel, out_valid});
      else n_pass++;
   endtask

   task automatic test_nominal();
      for (int r = 0; r < 3; r++) begin
         if (r == 0) begin
            srv_mem[0] = {9{8'h11}}; srv_mem[1] = {9{8'h22}}; srv_mem[2] = {9{8'h33}};
            srv_delay = 0; srv_done_delay = 0; ready_mode = 0;
         end else begin
            fill_random();
            srv_delay = $urandom_range(0, 3); srv_done_delay = $urandom_range(0, 3);
            ready_mode = 1;
         end
         srv_limit = NK; srv_silent = 0;
         run_set(200);
         n_checks++;
         if (got_data.size() !== NK)
            $display("FAIL nominal_count r%0d got %0d exp %0d", r, got_data.size(), NK);
         else begin
            n_pass++;
            for (int i = 0; i < NK; i++) begin
               n_checks++;
               if (got_data[i] !== srv_mem[i] || got_idx[i] !== i)
                  $display("FAIL nominal_kernel r%0d.%0d got %h/%0d exp %h/%0d",
                           r, i, got_data[i], got_idx[i], srv_mem[i], i);
               else n_pass++;
            end
         end
         n_checks++;
         if (n_done !== 1 || error !== 1'b0 || busy !== 1'b0 || nk_rises !== NK)
            $display("FAIL nominal_status r%0d got done=%0d err=%b busy=%b rises=%0d exp 1/0/0/%0d",
                     r, n_done, error, busy, nk_rises, NK);
         else n_pass++;
         if (r == 0) begin
            n_checks++;
            if (n_valid_cyc !== NK)
               $display("FAIL nominal_valid_cycles got %0d exp %0d", n_valid_cyc, NK);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      fill_random();
      srv_limit = NK; srv_silent = 0; srv_delay = 0; srv_done_delay = 0; ready_mode = 0;
      run_set(100);
      n_checks++;
      if (acc_cyc.size() !== NK)
         $display("FAIL b2b_count got %0d exp %0d", acc_cyc.size(), NK);
      else begin
         n_pass++;
         for (int i = 1; i < NK; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 3)
               $display("FAIL b2b_spacing[%0d] got %0d exp 3", i, acc_cyc[i] - acc_cyc[i-1]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_pressure();
      fill_random();
      srv_limit = NK; srv_silent = 0; srv_delay = $urandom_range(0, 2); srv_done_delay = 0;
      ready_mode = 2; stall_left[0] = 0; stall_left[1] = 20; stall_left[2] = 6;
      run_set(300);
      n_checks++;
      if (unstable !== 0 || nk_in_hold !== 0)
         $display("FAIL bp_hold got unstable=%0d nk_in_hold=%0d exp 0/0", unstable, nk_in_hold);
      else n_pass++;
      n_checks++;
      if (got_data.size() !== NK || got_data[1] !== srv_mem[1] || got_idx[1] !== 1)
         $display("FAIL bp_kernel1 got n=%0d exp n=%0d", got_data.size(), NK);
      else n_pass++;
      n_checks++;
      if (n_done !== 1 || error !== 1'b0)
         $display("FAIL bp_status got done=%0d err=%b exp 1/0", n_done, error);
      else n_pass++;
      ready_mode = 0;
   endtask

   task automatic test_premature();
      fill_random();
      srv_limit = 1; srv_silent = 0; srv_delay = $urandom_range(0, 3); ready_mode = 0;
      run_set(100);
      n_checks++;
      if (got_data.size() !== 1 || got_data[0] !== srv_mem[0] || got_idx[0] !== 0)
         $display("FAIL premature_delivered got n=%0d exp 1", got_data.size());
      else n_pass++;
      n_checks++;
      if (error !== 1'b1 || n_done !== 1 || busy !== 1'b0)
         $display("FAIL premature_status got err=%b done=%0d busy=%b exp 1/1/0", error, n_done, busy);
      else n_pass++;
      srv_limit = NK;
   endtask

   task automatic test_timeout();
      srv_silent = 1; ready_mode = 0;
      n_done = 0;
      start = 1'b1;
      step();
      for (int i = 1; i < TO; i++) step();
      n_checks++;
      if (next_kernel !== 1'b1 || error !== 1'b0)
         $display("FAIL timeout_early got nk=%b err=%b exp 1/0", next_kernel, error);
      else n_pass++;
      step();
      n_checks++;
      if (next_kernel !== 1'b0 || error !== 1'b1 || done !== 1'b1)
         $display("FAIL timeout_fire got nk=%b err=%b done=%b exp 0/1/1", next_kernel, error, done);
      else n_pass++;
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b1)
         $display("FAIL timeout_after got busy=%b done=%b err=%b exp 0/0/1", busy, done, error);
      else n_pass++;
      srv_silent = 0;
   endtask

   task automatic test_start_ignored();
      fill_random();
      srv_limit = NK; srv_delay = $urandom_range(0, 3); srv_done_delay = $urandom_range(0, 3);
      ready_mode = 1; poke_busy = 1; poke_done = 1;
      run_set(200);
      poke_busy = 0; poke_done = 0;
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if (n_srv_start !== 1 || n_done !== 1 || busy !== 1'b0 || error !== 1'b0)
         $display("FAIL start_ignored got srv_start=%0d done=%0d busy=%b err=%b exp 1/1/0/0",
                  n_srv_start, n_done, busy, error);
      else n_pass++;
      n_checks++;
      if (got_data.size() !== NK || got_data[NK-1] !== srv_mem[NK-1] || got_idx[NK-1] !== NK-1)
         $display("FAIL start_ignored_seq got n=%0d exp %0d", got_data.size(), NK);
      else n_pass++;
   endtask

   task automatic test_reset_mid_set();
      bit reached = 0;
      fill_random();
      srv_limit = NK; srv_delay = 0; ready_mode = 2;
      stall_left[0] = 0; stall_left[1] = 100; stall_left[2] = 0;
      start = 1'b1;
      for (int i = 0; i < 60 && !reached; i++) begin
         step();
         if (out_valid && kernel_idx == 2'd1) reached = 1;
      end
      n_checks++;
      if (!reached) $display("FAIL rst_mid_reach got 0 exp 1");
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({srv_start, next_kernel, kernel_out, kernel_idx, out_valid, busy, done, error} !== '0)
         $display("FAIL rst_mid_async got %h exp 0",
                  {srv_start, next_kernel, kernel_out, kernel_idx, out_valid, busy, done, error});
      else n_pass++;
      @(negedge clk) rst = 1'b0;
      srv_wait = -1; srv_done_cnt = -1; nk_prev = 0; ov_prev = 0; ready_mode = 0;
      fill_random();
      run_set(100);
      n_checks++;
      if (got_data.size() !== NK || got_idx[0] !== 0 || got_data[0] !== srv_mem[0] || error !== 1'b0)
         $display("FAIL rst_mid_restart got n=%0d err=%b exp %0d/0", got_data.size(), error, NK);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_back_pressure();
      test_premature();
      test_timeout();
      test_start_ignored();
      test_reset_mid_set();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
